// File: rtl/pulse_word_gen.sv
// Pulse-train word generator: turns delay/width/period/count commands into one
// 8-bit fine-tick word per clk1x cycle for the downstream 8:1 serializer.
//
// state | meaning
// IDLE  | cmd_ready high, word_out zero, waiting for a command
// RUN   | emitting one word per cycle until the last tick of the train
module pulse_word_gen #(
  parameter int CNT_W  = 16,
  parameter int CNT8_W = 8
) (
  input  logic              clk1x,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CNT_W-1:0]  cmd_delay,
  input  logic [CNT_W-1:0]  cmd_width,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic [CNT8_W-1:0] cmd_count,
  input  logic              abort,
  output logic [7:0]        word_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int RW = CNT_W + 4;
  localparam logic signed [RW-1:0] EIGHT = RW'(8);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic signed [RW-1:0]     start_rel;
  logic signed [RW-1:0]     end_rel;
  logic [CNT_W-1:0]         period_r;
  logic [CNT8_W-1:0]        k_r;
  logic [CNT8_W-1:0]        count_r;
  logic                     degen_r;

  logic [CNT_W-1:0]         w_eff_in;
  logic                     illegal_in;
  logic                     accept;
  logic signed [RW-1:0]     per_s;
  logic signed [RW-1:0]     delay_s;
  logic signed [RW-1:0]     weff_s;
  logic [CNT8_W:0]          k_p1;
  logic [CNT8_W:0]          cnt_ext;
  logic                     is_last_k;
  logic                     is_pen_k;
  logic                     has_next;
  logic signed [RW-1:0]     last_end;
  logic                     frame_last;
  logic                     advance;
  logic signed [RW-1:0]     next_start;
  logic signed [RW-1:0]     next_end;
  logic [7:0]               word_c;
  logic signed [RW-1:0]     ti;

  always_comb begin
    w_eff_in   = (cmd_count > CNT8_W'(1) && cmd_width > cmd_period) ? cmd_period : cmd_width;
    illegal_in = (cmd_count > CNT8_W'(1)) && (cmd_period < CNT_W'(8));
    accept     = (state == IDLE) && cmd_valid && !abort;
    delay_s    = {4'b0000, cmd_delay};
    weff_s     = {4'b0000, w_eff_in};
    per_s      = {4'b0000, period_r};
  end

  // Pulse k and k+1 are the only candidates for the current frame since period >= 8
  always_comb begin
    k_p1       = {1'b0, k_r} + (CNT8_W+1)'(1);
    cnt_ext    = {1'b0, count_r};
    is_last_k  = (k_p1 == cnt_ext);
    is_pen_k   = ((k_p1 + (CNT8_W+1)'(1)) == cnt_ext);
    has_next   = (k_p1 < cnt_ext);
    last_end   = is_last_k ? end_rel : (end_rel + per_s);
    frame_last = (is_last_k || is_pen_k) && (last_end <= EIGHT);
    advance    = has_next && (end_rel <= EIGHT);
    next_start = advance ? (start_rel + per_s - EIGHT) : (start_rel - EIGHT);
    next_end   = advance ? (end_rel + per_s - EIGHT) : (end_rel - EIGHT);
    word_c     = 8'h00;
    ti         = '0;
    for (int i = 0; i < 8; i++) begin
      ti = RW'(i);
      if (ti >= start_rel && ti < end_rel)
        word_c[i] = 1'b1;
      if (has_next && ti >= start_rel + per_s && ti < end_rel + per_s)
        word_c[i] = 1'b1;
    end
  end

  always_ff @(posedge clk1x or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_out  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
      start_rel <= '0;
      end_rel   <= '0;
      period_r  <= '0;
      k_r       <= '0;
      count_r   <= '0;
      degen_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          word_out <= 8'h00;
          done     <= 1'b0;
          if (accept) begin
            if (illegal_in) begin
              err <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
              start_rel <= delay_s;
              end_rel   <= delay_s + weff_s;
              period_r  <= cmd_period;
              count_r   <= cmd_count;
              k_r       <= '0;
              degen_r   <= (cmd_count == '0) || (w_eff_in == '0);
            end
          end
        end
        RUN: begin
          if (abort) begin
            word_out  <= 8'h00;
            done      <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else if (degen_r || frame_last) begin
            word_out  <= degen_r ? 8'h00 : word_c;
            done      <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            word_out  <= word_c;
            done      <= 1'b0;
            start_rel <= next_start;
            end_rel   <= next_end;
            if (advance)
              k_r <= k_r + CNT8_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_word_gen.sv
// Bench for pulse_word_gen: directed and random trains compared against an
// absolute-tick reference model of the pulse windows.
module tb_pulse_word_gen;

  logic        clk1x;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_delay;
  logic [15:0] cmd_width;
  logic [15:0] cmd_period;
  logic [7:0]  cmd_count;
  logic        abort;
  logic [7:0]  word_out;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_err  = 1'b0;
  logic [7:0]  exp_q[$];

  pulse_word_gen #(.CNT_W(16), .CNT8_W(8)) dut (
    .clk1x(clk1x), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_delay(cmd_delay), .cmd_width(cmd_width), .cmd_period(cmd_period),
    .cmd_count(cmd_count), .abort(abort), .word_out(word_out), .busy(busy),
    .done(done), .err(err)
  );

  initial clk1x = 1'b0;
  always #5 clk1x = ~clk1x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Absolute-tick model: a tick is high when it falls inside any pulse window.
  task automatic build_expected(input int d, input int w, input int p, input int c);
    int weff;
    int tend;
    int t;
    logic [7:0] wd;
    exp_q.delete();
    weff = (c > 1 && w > p) ? p : w;
    if (c == 0 || weff == 0) begin
      exp_q.push_back(8'h00);
    end else begin
      tend = d + (c - 1) * p + weff - 1;
      for (int f = 0; f <= tend / 8; f++) begin
        wd = 8'h00;
        for (int i = 0; i < 8; i++) begin
          t = 8 * f + i;
          for (int k = 0; k < c; k++)
            if (t >= d + k * p && t < d + k * p + weff) wd[i] = 1'b1;
        end
        exp_q.push_back(wd);
      end
    end
  endtask

  task automatic drive_cmd(input int d, input int w, input int p, input int c);
    int waitc;
    waitc = 0;
    while (!cmd_ready && waitc < 50) begin
      @(negedge clk1x);
      waitc++;
    end
    if (!cmd_ready) check("ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_delay  = d[15:0];
    cmd_width  = w[15:0];
    cmd_period = p[15:0];
    cmd_count  = c[7:0];
    @(posedge clk1x);
    #1 cmd_valid = 1'b0;
  endtask

  // Starts at a negedge, returns at a negedge with the block idle again.
  task automatic run_cmd(input int d, input int w, input int p, input int c);
    int nf;
    build_expected(d, w, p, c);
    nf = exp_q.size();
    drive_cmd(d, w, p, c);
    @(negedge clk1x);
    if (c > 1 && p < 8) begin
      exp_err = 1'b1;
      check("ill_err", {31'b0, err}, 32'd1);
      check("ill_busy", {31'b0, busy}, 32'd0);
      check("ill_ready", {31'b0, cmd_ready}, 32'd1);
      check("ill_word", {24'b0, word_out}, 32'd0);
      check("ill_done", {31'b0, done}, 32'd0);
      @(negedge clk1x);
      check("ill_done2", {31'b0, done}, 32'd0);
      return;
    end
    check("acc_busy", {31'b0, busy}, 32'd1);
    check("acc_ready", {31'b0, cmd_ready}, 32'd0);
    for (int f = 0; f < nf; f++) begin
      @(negedge clk1x);
      check("word", {24'b0, word_out}, {24'b0, exp_q[f]});
      check("done", {31'b0, done}, (f == nf - 1) ? 32'd1 : 32'd0);
      check("busy", {31'b0, busy}, (f == nf - 1) ? 32'd0 : 32'd1);
    end
    @(negedge clk1x);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_word", {24'b0, word_out}, 32'd0);
    check("post_done", {31'b0, done}, 32'd0);
    check("post_err", {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    int d, w, p, c;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_delay  = '0;
    cmd_width  = '0;
    cmd_period = '0;
    cmd_count  = '0;
    abort      = 1'b0;
    #12;
    check("rst_word", {24'b0, word_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk1x);
    rst_n = 1'b1;
    @(negedge clk1x);

    run_cmd(0, 3, 0, 1);
    run_cmd(5, 6, 0, 1);
    run_cmd(0, 2, 10, 3);
    run_cmd(4, 20, 8, 3);
    run_cmd(0, 0, 8, 2);
    run_cmd(3, 5, 9, 0);
    run_cmd(0, 3, 4, 2);
    run_cmd(7, 1, 8, 4);
    run_cmd(8, 8, 0, 1);

    // abort mid-train
    build_expected(0, 100, 8, 1);
    drive_cmd(0, 100, 8, 1);
    @(negedge clk1x);
    for (int f = 0; f < 3; f++) begin
      @(negedge clk1x);
      check("abt_word", {24'b0, word_out}, {24'b0, exp_q[f]});
    end
    abort = 1'b1;
    @(posedge clk1x);
    #1 abort = 1'b0;
    @(negedge clk1x);
    check("abt_word0", {24'b0, word_out}, 32'd0);
    check("abt_done", {31'b0, done}, 32'd0);
    check("abt_busy", {31'b0, busy}, 32'd0);
    check("abt_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk1x);
    check("abt_done2", {31'b0, done}, 32'd0);

    // abort wins over acceptance in the same cycle
    abort      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_delay  = 16'd0;
    cmd_width  = 16'd4;
    cmd_period = 16'd8;
    cmd_count  = 8'd1;
    @(posedge clk1x);
    #1;
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("abtacc_busy", {31'b0, busy}, 32'd0);
    check("abtacc_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk1x);
    @(negedge clk1x);
    check("abtacc_word", {24'b0, word_out}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 4);
      p = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(8, 20);
      d = $urandom_range(0, 30);
      w = $urandom_range(0, 25);
      run_cmd(d, w, p, c);
    end

    // reset mid-train clears everything asynchronously
    drive_cmd(2, 100, 8, 1);
    repeat (4) @(negedge clk1x);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_word", {24'b0, word_out}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_err", {31'b0, err}, 32'd0);
    check("mrst_ready", {31'b0, cmd_ready}, 32'd1);
    exp_err = 1'b0;
    @(negedge clk1x);
    rst_n = 1'b1;
    @(negedge clk1x);
    run_cmd(1, 9, 12, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
